// File: rtl/rv32i_pkg.sv
// Shared RV32I constants and types for the writeback path and register file.
package rv32i_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: rotating pointer, wrap-around first-one search, one-hot grant.
module rr_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic                                         clock,
    input  logic                                         reset_n,
    input  logic                                         stall,
    input  logic [NUM_REQ-1:0]                           valid,
    output logic [NUM_REQ-1:0]                           grant,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_idx,
    output logic                                         transfer
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0] ptr_reg;
    logic [IDX_W-1:0] ptr_next;
    logic             found;

    // Scan from the pointer upward, wrapping past NUM_REQ-1 back to 0.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            int idx;
            idx = int'(ptr_reg) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && valid[idx]) begin
                found     = 1'b1;
                grant_idx = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        grant = '0;
        if (found && !stall && reset_n) begin
            grant = NUM_REQ'(1) << grant_idx;
        end
        transfer = |grant;
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (transfer) begin
            ptr_next = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NUM_REQ writeback sources; x0 writes are dropped.
module regfile_wb_arbiter
    import rv32i_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = rv32i_pkg::XLEN,
    parameter int CNT_W   = 16
) (
    input  logic                                  clock,
    input  logic                                  reset_n,
    input  logic                                  stall_i,
    input  logic [NUM_REQ-1:0]                    req_valid_i,
    input  logic [NUM_REQ-1:0][REG_ADDR_W-1:0]    req_addr_i,
    input  logic [NUM_REQ-1:0][XLEN-1:0]          req_data_i,
    output logic [NUM_REQ-1:0]                    req_ready_o,
    output logic [REG_ADDR_W-1:0]                 rd_addr_o,
    output logic                                  wr_en_o,
    output logic [XLEN-1:0]                       wr_data_o,
    output logic [CNT_W-1:0]                      contention_cnt_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]                 grant;
    logic [IDX_W-1:0]                   grant_idx;
    logic                               transfer;
    logic [NUM_REQ-1:0][REG_ADDR_W-1:0] masked_addr;
    logic [NUM_REQ-1:0][XLEN-1:0]       masked_data;
    logic [REG_ADDR_W-1:0]              win_addr;
    logic [XLEN-1:0]                    win_data;
    logic                               multi_valid;

    logic [REG_ADDR_W-1:0] rd_addr_reg;
    logic                  wr_en_reg;
    logic [XLEN-1:0]       wr_data_reg;
    logic [CNT_W-1:0]      cnt_reg;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clock     (clock),
        .reset_n   (reset_n),
        .stall     (stall_i),
        .valid     (req_valid_i),
        .grant     (grant),
        .grant_idx (grant_idx),
        .transfer  (transfer)
    );

    // Grant is one-hot, so an AND-OR mux selects the winning request.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_mask
            assign masked_addr[gi] = req_addr_i[gi] & {REG_ADDR_W{grant[gi]}};
            assign masked_data[gi] = req_data_i[gi] & {XLEN{grant[gi]}};
        end
    endgenerate

    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_addr = win_addr | masked_addr[i];
            win_data = win_data | masked_data[i];
        end
    end

    assign multi_valid = ($countones(req_valid_i) >= 2);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_addr_reg <= '0;
            wr_en_reg   <= 1'b0;
            wr_data_reg <= '0;
            cnt_reg     <= '0;
        end else begin
            wr_en_reg <= 1'b0;
            if (transfer) begin
                rd_addr_reg <= win_addr;
                wr_data_reg <= win_data;
                wr_en_reg   <= (win_addr != REG_ZERO);
            end
            if (multi_valid && (cnt_reg != {CNT_W{1'b1}})) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign req_ready_o      = grant;
    assign rd_addr_o        = rd_addr_reg;
    assign wr_en_o          = wr_en_reg;
    assign wr_data_o        = wr_data_reg;
    assign contention_cnt_o = cnt_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; a second instance with CNT_W=4 covers counter saturation.
module tb_regfile_wb_arbiter;

    logic             clock;
    logic             reset_n;
    logic             stall;
    logic [2:0]       valid;
    logic [2:0][4:0]  addr;
    logic [2:0][31:0] data;

    logic [2:0]       ready;
    logic [4:0]       rd_addr;
    logic             wr_en;
    logic [31:0]      wr_data;
    logic [15:0]      cnt;

    logic [2:0]       ready_s;
    logic [4:0]       rd_addr_s;
    logic             wr_en_s;
    logic [31:0]      wr_data_s;
    logic [3:0]       cnt_s;

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter #(.NUM_REQ(3), .XLEN(32), .CNT_W(16)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .stall_i          (stall),
        .req_valid_i      (valid),
        .req_addr_i       (addr),
        .req_data_i       (data),
        .req_ready_o      (ready),
        .rd_addr_o        (rd_addr),
        .wr_en_o          (wr_en),
        .wr_data_o        (wr_data),
        .contention_cnt_o (cnt)
    );

    regfile_wb_arbiter #(.NUM_REQ(3), .XLEN(32), .CNT_W(4)) dut_sat (
        .clock            (clock),
        .reset_n          (reset_n),
        .stall_i          (stall),
        .req_valid_i      (valid),
        .req_addr_i       (addr),
        .req_data_i       (data),
        .req_ready_o      (ready_s),
        .rd_addr_o        (rd_addr_s),
        .wr_en_o          (wr_en_s),
        .wr_data_o        (wr_data_s),
        .contention_cnt_o (cnt_s)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change at the falling edge; outputs are sampled 1 ns later.
    task automatic apply_reset();
        @(negedge clock);
        reset_n = 1'b0;
        stall   = 1'b0;
        valid   = 3'b000;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset_n = 1'b0;
        stall   = 1'b0;
        valid   = 3'b111;
        addr    = {5'd3, 5'd2, 5'd1};
        data    = {32'hA2, 32'hA1, 32'hA0};
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #1;
            checks++;
            if (ready !== 3'b000) begin
                errors++;
                $display("FAIL reset_ready cyc%0d: got %b expected 000", i, ready);
            end
            checks++;
            if (wr_en !== 1'b0 || cnt !== 16'd0) begin
                errors++;
                $display("FAIL reset_outputs cyc%0d: wr_en=%b cnt=%0d expected 0/0", i, wr_en, cnt);
            end
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if (ready !== 3'b001) begin
            errors++;
            $display("FAIL reset_first_grant: got %b expected 001", ready);
        end
        @(negedge clock);
        #1;
        checks++;
        if (wr_en !== 1'b1 || rd_addr !== 5'd1 || wr_data !== 32'hA0 || cnt !== 16'd1) begin
            errors++;
            $display("FAIL reset_first_write: wr_en=%b rd=%0d data=%h cnt=%0d expected 1/1/a0/1",
                     wr_en, rd_addr, wr_data, cnt);
        end
        $display("test_reset done: first grant to req0");
        valid = 3'b000;
    endtask

    task automatic test_single();
        apply_reset();
        valid   = 3'b010;
        addr[1] = 5'd5;
        data[1] = 32'hDEADBEEF;
        #1;
        checks++;
        if (ready !== 3'b010) begin
            errors++;
            $display("FAIL single_ready: got %b expected 010", ready);
        end
        @(negedge clock);
        valid = 3'b000;
        #1;
        checks++;
        if (wr_en !== 1'b1 || rd_addr !== 5'd5 || wr_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_write: wr_en=%b rd=%0d data=%h expected 1/5/deadbeef",
                     wr_en, rd_addr, wr_data);
        end
        @(negedge clock);
        #1;
        checks++;
        if (wr_en !== 1'b0 || rd_addr !== 5'd5 || wr_data !== 32'hDEADBEEF || cnt !== 16'd0) begin
            errors++;
            $display("FAIL single_after: wr_en=%b rd=%0d data=%h cnt=%0d expected 0/5/deadbeef/0",
                     wr_en, rd_addr, wr_data, cnt);
        end
        $display("test_single done: req1 addr 5 data deadbeef");
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_grant;
        apply_reset();
        valid = 3'b111;
        addr  = {5'd3, 5'd2, 5'd1};
        data  = {32'hC2, 32'hC1, 32'hC0};
        for (int k = 0; k < 6; k++) begin
            #1;
            exp_grant = 3'b001 << (k % 3);
            checks++;
            if (ready !== exp_grant || cnt !== 16'(k)) begin
                errors++;
                $display("FAIL rr_grant k%0d: ready=%b cnt=%0d expected %b/%0d", k, ready, cnt, exp_grant, k);
            end
            if (k > 0) begin
                checks++;
                if (wr_en !== 1'b1 || rd_addr !== 5'(((k - 1) % 3) + 1)) begin
                    errors++;
                    $display("FAIL rr_write k%0d: wr_en=%b rd=%0d expected 1/%0d", k, wr_en, rd_addr, ((k - 1) % 3) + 1);
                end
            end
            @(negedge clock);
        end
        #1;
        checks++;
        if (wr_en !== 1'b1 || rd_addr !== 5'd3 || wr_data !== 32'hC2 || cnt !== 16'd6) begin
            errors++;
            $display("FAIL rr_last: wr_en=%b rd=%0d data=%h cnt=%0d expected 1/3/c2/6", wr_en, rd_addr, wr_data, cnt);
        end
        $display("test_round_robin done: grants 0,1,2,0,1,2");
        valid = 3'b000;
    endtask

    task automatic test_x0();
        apply_reset();
        valid   = 3'b001;
        addr[0] = 5'd0;
        data[0] = 32'h1234;
        #1;
        checks++;
        if (ready !== 3'b001) begin
            errors++;
            $display("FAIL x0_ready: got %b expected 001", ready);
        end
        @(negedge clock);
        valid   = 3'b011;
        addr[1] = 5'd6;
        #1;
        checks++;
        if (wr_en !== 1'b0 || wr_data !== 32'h1234 || rd_addr !== 5'd0) begin
            errors++;
            $display("FAIL x0_suppress: wr_en=%b rd=%0d data=%h expected 0/0/1234", wr_en, rd_addr, wr_data);
        end
        checks++;
        if (ready !== 3'b010) begin
            errors++;
            $display("FAIL x0_pointer: ready=%b expected 010", ready);
        end
        @(negedge clock);
        valid = 3'b000;
        #1;
        checks++;
        if (wr_en !== 1'b1 || rd_addr !== 5'd6) begin
            errors++;
            $display("FAIL x0_next_write: wr_en=%b rd=%0d expected 1/6", wr_en, rd_addr);
        end
        $display("test_x0 done: x0 accepted without write enable");
    endtask

    task automatic test_stall();
        apply_reset();
        valid   = 3'b010;
        addr    = {5'd9, 5'd7, 5'd8};
        data    = {32'h92, 32'h71, 32'h80};
        @(negedge clock);
        valid = 3'b101;
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (ready !== 3'b000) begin
                errors++;
                $display("FAIL stall_ready cyc%0d: got %b expected 000", i, ready);
            end
            @(negedge clock);
            #1;
            checks++;
            if (wr_en !== 1'b0) begin
                errors++;
                $display("FAIL stall_wr_en cyc%0d: got %b expected 0", i, wr_en);
            end
        end
        stall = 1'b0;
        #1;
        checks++;
        if (ready !== 3'b100 || cnt !== 16'd4) begin
            errors++;
            $display("FAIL stall_release: ready=%b cnt=%0d expected 100/4", ready, cnt);
        end
        @(negedge clock);
        #1;
        checks++;
        if (wr_en !== 1'b1 || rd_addr !== 5'd9 || wr_data !== 32'h92 || cnt !== 16'd5 || ready !== 3'b001) begin
            errors++;
            $display("FAIL stall_after: wr_en=%b rd=%0d data=%h cnt=%0d ready=%b expected 1/9/92/5/001",
                     wr_en, rd_addr, wr_data, cnt, ready);
        end
        $display("test_stall done: pointer held across 4 stall cycles");
        valid = 3'b000;
    endtask

    task automatic test_saturation();
        apply_reset();
        stall = 1'b1;
        valid = 3'b011;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            #1;
            if (k == 14 || k == 15 || k == 20) begin
                checks++;
                if (cnt_s !== 4'((k > 15) ? 15 : k) || cnt !== 16'(k)) begin
                    errors++;
                    $display("FAIL sat_count k%0d: cnt_s=%0d cnt=%0d expected %0d/%0d",
                             k, cnt_s, cnt, (k > 15) ? 15 : k, k);
                end
            end
        end
        $display("test_saturation done: 4-bit counter holds at 15");
        stall = 1'b0;
        valid = 3'b000;
    endtask

    initial begin
        reset_n = 1'b0;
        stall   = 1'b0;
        valid   = 3'b000;
        addr    = '0;
        data    = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_x0();
        test_stall();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
